// File: rtl/approx_add_err_monitor.sv
// Error-distance monitor for the approximate adder: recomputes the exact sum per sample
// and accumulates windowed error statistics (count, max, saturating sum).
module approx_add_err_monitor #(
    parameter int WIDTH    = 24,
    parameter int WIN_LOG2 = 8,
    parameter int ACC_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  cin,
    input  logic [WIDTH-1:0]      s_appr,
    input  logic                  cout_appr,
    output logic                  busy,
    output logic                  done,
    output logic [WIN_LOG2:0]     err_count,
    output logic [WIDTH:0]        max_ed,
    output logic [ACC_W-1:0]      sum_ed
);

    // state | meaning
    // IDLE  | waiting for start, no samples accepted
    // RUN   | accepting samples until the window is full
    // DRAIN | window full, flushing the pipeline into the statistics
    // DONE  | statistics valid and held until the next start

    localparam int EW = WIDTH + 1;
    localparam int CW = WIN_LOG2 + 1;
    localparam int SW = ACC_W + 1;
    localparam logic [CW-1:0]    LAST_IDX = CW'((1 << WIN_LOG2) - 1);
    localparam logic [ACC_W-1:0] SUM_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              clear, accept;

    logic              s1_vld_q;
    logic [WIDTH-1:0]  s1_a_q, s1_b_q, s1_s_q;
    logic              s1_cin_q, s1_cout_q;

    logic              s2_vld_q;
    logic [EW-1:0]     s2_ed_q, ed_d;
    logic [EW-1:0]     exact, appr;

    logic [CW-1:0]     err_q, err_d;
    logic [EW-1:0]     max_q, max_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [SW-1:0]     sum_ext;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && cnt_q == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!s1_vld_q && !s2_vld_q) state_d = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    clear   = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (accept) cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        exact = {1'b0, s1_a_q} + {1'b0, s1_b_q} + EW'(s1_cin_q);
        appr  = {s1_cout_q, s1_s_q};
        ed_d  = (exact >= appr) ? (exact - appr) : (appr - exact);
    end

    // Carry bit of the widened add flags overflow of the accumulator.
    always_comb begin
        err_d   = err_q;
        max_d   = max_q;
        sum_d   = sum_q;
        sum_ext = SW'(sum_q) + SW'(s2_ed_q);
        if (clear) begin
            err_d = '0;
            max_d = '0;
            sum_d = '0;
        end else if (s2_vld_q) begin
            err_d = err_q + CW'(s2_ed_q != '0);
            if (s2_ed_q > max_q) max_d = s2_ed_q;
            sum_d = sum_ext[ACC_W] ? SUM_MAX : sum_ext[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_s_q    <= '0;
            s1_cin_q  <= 1'b0;
            s1_cout_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_ed_q   <= '0;
            err_q     <= '0;
            max_q     <= '0;
            sum_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s1_vld_q <= accept;
            if (accept) begin
                s1_a_q    <= a;
                s1_b_q    <= b;
                s1_s_q    <= s_appr;
                s1_cin_q  <= cin;
                s1_cout_q <= cout_appr;
            end
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) s2_ed_q <= ed_d;
            err_q <= err_d;
            max_q <= max_d;
            sum_q <= sum_d;
        end
    end

    assign err_count = err_q;
    assign max_ed    = max_q;
    assign sum_ed    = sum_q;

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor: full windows with known error patterns,
// handshake gaps, restart from DONE and asynchronous reset mid-window.
module tb_approx_add_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        cout_appr = 1'b0;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic [23:0] s_appr = '0;
    logic        in_ready, busy, done;
    logic [8:0]  err_count;
    logic [24:0] max_ed;
    logic [31:0] sum_ed;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_add_err_monitor #(.WIDTH(24), .WIN_LOG2(8), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .s_appr(s_appr), .cout_appr(cout_appr),
        .busy(busy), .done(done), .err_count(err_count), .max_ed(max_ed), .sum_ed(sum_ed)
    );

    // mode 0: 0x10+0x01 with exact result, except index err_idx gets s_appr=0x15 (ed=4)
    // mode 1: 0xFFFFFF+0x01 against an approximate result of 0 (ed=0x1000000)
    task automatic set_sample(input int mode, input int k, input int err_idx);
        if (mode == 0) begin
            a = 24'h000010; b = 24'h000001; cin = 1'b0; cout_appr = 1'b0;
            s_appr = (k == err_idx) ? 24'h000015 : 24'h000011;
        end else begin
            a = 24'hFFFFFF; b = 24'h000001; cin = 1'b0; cout_appr = 1'b0;
            s_appr = 24'h000000;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers samples until done; counts handshakes seen before each rising edge.
    task automatic feed(input int mode, input int err_idx, input bit gaps,
                        input bit poke_start, output int hs);
        bit fin;
        hs  = 0;
        fin = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            if (done) begin
                fin = 1'b1;
                break;
            end
            set_sample(mode, hs, err_idx);
            in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            start    = poke_start && (cyc % 37 == 5);
            if (in_valid && in_ready) hs++;
            @(posedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL window_timeout: done=%0b required done=1 within budget", done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b want 0", done); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        checks++; if (max_ed !== 25'd0) begin failures++; $display("FAIL rst_max_ed: got %0h want 0", max_ed); end
        checks++; if (sum_ed !== 32'd0) begin failures++; $display("FAIL rst_sum_ed: got %0h want 0", sum_ed); end
        @(negedge clk);
        rst_n = 1'b1;
        set_sample(0, 0, 0);
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready: got %0b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %0b want 0", busy); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL idle_err_count: got %0d want 0", err_count); end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_error();
        int hs;
        pulse_start();
        feed(0, -1, 1'b0, 1'b0, hs);
        checks++; if (hs !== 256) begin failures++; $display("FAIL zero_handshakes: got %0d want 256", hs); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0b want 0", busy); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL zero_err_count: got %0d want 0", err_count); end
        checks++; if (max_ed !== 25'd0) begin failures++; $display("FAIL zero_max_ed: got %0h want 0", max_ed); end
        checks++; if (sum_ed !== 32'd0) begin failures++; $display("FAIL zero_sum_ed: got %0h want 0", sum_ed); end
    endtask

    task automatic test_single_error();
        int hs;
        int pos [3] = '{0, 127, 255};
        for (int i = 0; i < 3; i++) begin
            pulse_start();
            feed(0, pos[i], 1'b0, 1'b0, hs);
            checks++; if (hs !== 256) begin failures++; $display("FAIL single_handshakes[%0d]: got %0d want 256", pos[i], hs); end
            checks++; if (err_count !== 9'd1) begin failures++; $display("FAIL single_err_count[%0d]: got %0d want 1", pos[i], err_count); end
            checks++; if (max_ed !== 25'd4) begin failures++; $display("FAIL single_max_ed[%0d]: got %0h want 4", pos[i], max_ed); end
            checks++; if (sum_ed !== 32'd4) begin failures++; $display("FAIL single_sum_ed[%0d]: got %0h want 4", pos[i], sum_ed); end
        end
    endtask

    task automatic test_carry_saturation();
        int hs;
        pulse_start();
        feed(1, -1, 1'b0, 1'b0, hs);
        checks++; if (hs !== 256) begin failures++; $display("FAIL carry_handshakes: got %0d want 256", hs); end
        checks++; if (err_count !== 9'h100) begin failures++; $display("FAIL carry_err_count: got %0d want 256", err_count); end
        checks++; if (max_ed !== 25'h1000000) begin failures++; $display("FAIL carry_max_ed: got %0h want 1000000", max_ed); end
        checks++; if (sum_ed !== 32'hFFFFFFFF) begin failures++; $display("FAIL carry_sum_sat: got %0h want ffffffff", sum_ed); end
    endtask

    task automatic test_gaps();
        int hs;
        pulse_start();
        feed(0, 100, 1'b1, 1'b1, hs);
        checks++; if (hs !== 256) begin failures++; $display("FAIL gaps_handshakes: got %0d want 256", hs); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %0b want 1", done); end
        checks++; if (err_count !== 9'd1) begin failures++; $display("FAIL gaps_err_count: got %0d want 1", err_count); end
        checks++; if (max_ed !== 25'd4) begin failures++; $display("FAIL gaps_max_ed: got %0h want 4", max_ed); end
        checks++; if (sum_ed !== 32'd4) begin failures++; $display("FAIL gaps_sum_ed: got %0h want 4", sum_ed); end
    endtask

    task automatic test_restart();
        int hs;
        pulse_start();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL restart_done: got %0b want 0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %0b want 1", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL restart_in_ready: got %0b want 1", in_ready); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL restart_err_count: got %0d want 0", err_count); end
        checks++; if (max_ed !== 25'd0) begin failures++; $display("FAIL restart_max_ed: got %0h want 0", max_ed); end
        checks++; if (sum_ed !== 32'd0) begin failures++; $display("FAIL restart_sum_ed: got %0h want 0", sum_ed); end
        feed(1, -1, 1'b0, 1'b0, hs);
        checks++; if (hs !== 256) begin failures++; $display("FAIL restart_handshakes: got %0d want 256", hs); end
        checks++; if (err_count !== 9'h100) begin failures++; $display("FAIL restart_win_err: got %0d want 256", err_count); end
        checks++; if (sum_ed !== 32'hFFFFFFFF) begin failures++; $display("FAIL restart_win_sum: got %0h want ffffffff", sum_ed); end
    endtask

    task automatic test_reset_mid_window();
        int hs = 0;
        pulse_start();
        for (int cyc = 0; cyc < 400 && hs < 100; cyc++) begin
            @(negedge clk);
            set_sample(1, hs, -1);
            in_valid = 1'b1;
            if (in_ready) hs++;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (err_count !== 9'd100) begin failures++; $display("FAIL mid_err_count: got %0d want 100", err_count); end
        checks++; if (sum_ed !== 32'h64000000) begin failures++; $display("FAIL mid_sum_ed: got %0h want 64000000", sum_ed); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %0b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL async_in_ready: got %0b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_busy: got %0b want 0", busy); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL async_err_count: got %0d want 0", err_count); end
        checks++; if (max_ed !== 25'd0) begin failures++; $display("FAIL async_max_ed: got %0h want 0", max_ed); end
        checks++; if (sum_ed !== 32'd0) begin failures++; $display("FAIL async_sum_ed: got %0h want 0", sum_ed); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL post_rst_in_ready: got %0b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL post_rst_done: got %0b want 0", done); end
        checks++; if (err_count !== 9'd0) begin failures++; $display("FAIL post_rst_err_count: got %0d want 0", err_count); end
        in_valid = 1'b0;
        pulse_start();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_start: got %0b want 1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_zero_error();
        test_single_error();
        test_carry_saturation();
        test_gaps();
        test_restart();
        test_reset_mid_window();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
